// File: rtl/pipe_rx_decoder_pkg.sv
// Shared types and constants for the host pipe-in command decoder.
package pipe_rx_pkg;

  localparam int FRAME_WORDS = 5;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // One state per word position in the frame.
  typedef enum logic [$clog2(FRAME_WORDS)-1:0] {
    ST_HUNT,
    ST_ADDR,
    ST_DHI,
    ST_DLO,
    ST_CSUM
  } rx_state_e;

endpackage

// File: rtl/pipe_rx_decoder_if.sv
// Host word stream in, decoded command handshake and status out.
interface pipe_rx_decoder_if;
  logic        pipe_write_in;
  logic [15:0] data_in;
  logic        cmd_ready_in;
  logic        cmd_valid_out;
  logic [3:0]  cmd_chan_out;
  logic [7:0]  cmd_addr_out;
  logic [31:0] cmd_data_out;
  logic [15:0] frame_count_out;
  logic [15:0] err_count_out;
  logic        overflow_out;

  modport master (
    output pipe_write_in, data_in, cmd_ready_in,
    input  cmd_valid_out, cmd_chan_out, cmd_addr_out, cmd_data_out,
    input  frame_count_out, err_count_out, overflow_out
  );

  modport slave (
    input  pipe_write_in, data_in, cmd_ready_in,
    output cmd_valid_out, cmd_chan_out, cmd_addr_out, cmd_data_out,
    output frame_count_out, err_count_out, overflow_out
  );
endinterface

// File: rtl/pipe_rx_decoder_cmd_out_reg.sv
// One-entry valid/ready command holding register; flags frames that arrive while full.
module cmd_out_reg (
  input  logic        ti_clk_in,
  input  logic        rst_n_in,
  input  logic        load_req,
  input  logic [3:0]  load_chan,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic        ready,
  output logic        valid,
  output logic [3:0]  chan,
  output logic [7:0]  addr,
  output logic [31:0] data,
  output logic        loaded,
  output logic        overflow
);

  logic consume;

  // A slot frees up either when empty or when the held entry leaves this cycle.
  always_comb begin
    consume = valid && ready;
    loaded  = load_req && (!valid || consume);
  end

  always_ff @(posedge ti_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid    <= 1'b0;
      chan     <= '0;
      addr     <= '0;
      data     <= '0;
      overflow <= 1'b0;
    end else begin
      if (loaded) begin
        valid <= 1'b1;
        chan  <= load_chan;
        addr  <= load_addr;
        data  <= load_data;
      end else if (consume) begin
        valid <= 1'b0;
      end
      if (load_req && !loaded) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_rx_decoder.sv
// Decodes 5-word checksummed host frames into single parameter-write commands.
module pipe_rx_decoder
  import pipe_rx_pkg::*;
#(
  parameter int         N_ADC     = 6,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TIMEOUT   = 1024
) (
  input  logic             ti_clk_in,
  input  logic             rst_n_in,
  pipe_rx_decoder_if.slave bus
);

  localparam int          IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [7:0]  N_ADC_B   = 8'(N_ADC);

  rx_state_e         state, state_nxt;
  logic [15:0]       csum;
  logic [7:0]        hdr_chan;
  logic [7:0]        par_addr;
  logic              w1_bad;
  logic [15:0]       dat_hi, dat_lo;
  logic [IDLE_W-1:0] idle_cnt;
  logic [15:0]       frame_cnt, err_cnt;

  logic strobe, sync_ok, frame_ok;
  logic good_evt, err_evt, timeout_evt;
  logic cmd_loaded;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    strobe      = bus.pipe_write_in;
    sync_ok     = (bus.data_in[15:8] == SYNC_BYTE);
    frame_ok    = (bus.data_in == csum) && (hdr_chan < N_ADC_B) && !w1_bad;
    state_nxt   = state;
    good_evt    = 1'b0;
    err_evt     = 1'b0;
    timeout_evt = 1'b0;
    if (strobe) begin
      case (state)
        ST_HUNT: if (sync_ok) state_nxt = ST_ADDR;
                 else         err_evt   = 1'b1;
        ST_ADDR: state_nxt = ST_DHI;
        ST_DHI:  state_nxt = ST_DLO;
        ST_DLO:  state_nxt = ST_CSUM;
        ST_CSUM: begin
          state_nxt = ST_HUNT;
          good_evt  = frame_ok;
          err_evt   = !frame_ok;
        end
        default: state_nxt = ST_HUNT;
      endcase
    end else if (state != ST_HUNT && idle_cnt == IDLE_LAST) begin
      // Host stalled mid-frame: abandon the partial frame.
      timeout_evt = 1'b1;
      err_evt     = 1'b1;
      state_nxt   = ST_HUNT;
    end
  end

  always_ff @(posedge ti_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_HUNT;
    else           state <= state_nxt;
  end

  // Frame capture: running XOR plus field registers, one word per strobe.
  always_ff @(posedge ti_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      csum     <= '0;
      hdr_chan <= '0;
      par_addr <= '0;
      w1_bad   <= 1'b0;
      dat_hi   <= '0;
      dat_lo   <= '0;
    end else if (state == ST_HUNT) begin
      csum     <= (strobe && sync_ok) ? bus.data_in : 16'h0000;
      hdr_chan <= bus.data_in[7:0];
    end else if (strobe) begin
      csum <= csum ^ bus.data_in;
      case (state)
        ST_ADDR: begin
          par_addr <= bus.data_in[7:0];
          w1_bad   <= |bus.data_in[15:8];
        end
        ST_DHI:  dat_hi <= bus.data_in;
        ST_DLO:  dat_lo <= bus.data_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ti_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      idle_cnt  <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (strobe || state == ST_HUNT || timeout_evt) idle_cnt <= '0;
      else                                           idle_cnt <= idle_cnt + 1'b1;
      if (cmd_loaded) frame_cnt <= sat_inc16(frame_cnt);
      if (err_evt)    err_cnt   <= sat_inc16(err_cnt);
    end
  end

  cmd_out_reg u_cmd_out_reg (
    .ti_clk_in (ti_clk_in),
    .rst_n_in  (rst_n_in),
    .load_req  (good_evt),
    .load_chan (hdr_chan[3:0]),
    .load_addr (par_addr),
    .load_data ({dat_hi, dat_lo}),
    .ready     (bus.cmd_ready_in),
    .valid     (bus.cmd_valid_out),
    .chan      (bus.cmd_chan_out),
    .addr      (bus.cmd_addr_out),
    .data      (bus.cmd_data_out),
    .loaded    (cmd_loaded),
    .overflow  (bus.overflow_out)
  );

  assign bus.frame_count_out = frame_cnt;
  assign bus.err_count_out   = err_cnt;

endmodule

// File: tb/tb_pipe_rx_decoder.sv
// Directed scoreboard bench for pipe_rx_decoder: expected commands queued at issue, checked on handshake.
module tb_pipe_rx_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_rx_decoder_if bus ();

  pipe_rx_decoder #(.N_ADC(6), .SYNC_BYTE(8'hA5), .TIMEOUT(1024)) dut (
    .ti_clk_in (clk),
    .rst_n_in  (rst_n),
    .bus       (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [43:0] exp_q[$];

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [43:0] pk(input logic [3:0] c, input logic [7:0] a, input logic [31:0] d);
    return {c, a, d};
  endfunction

  function automatic logic [43:0] cur_cmd();
    return {bus.cmd_chan_out, bus.cmd_addr_out, bus.cmd_data_out};
  endfunction

  // Monitor: every accepted command must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.cmd_valid_out && bus.cmd_ready_in) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cmd_unexpected: got %0h expected none", cur_cmd());
      end else begin
        check("cmd_payload", cur_cmd(), exp_q.pop_front());
      end
    end
  end

  task automatic put_word(input logic [15:0] w);
    bus.pipe_write_in = 1'b1;
    bus.data_in       = w;
    @(posedge clk);
    #1;
    bus.pipe_write_in = 1'b0;
    bus.data_in       = 16'h0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] chan, input logic [7:0] addr, input logic [31:0] d,
                            input logic [7:0] w1hi, input logic flip, input logic rdy_last);
    logic [15:0] w0, w1, w2, w3, w4;
    w0 = {8'hA5, chan};
    w1 = {w1hi, addr};
    w2 = d[31:16];
    w3 = d[15:0];
    w4 = w0 ^ w1 ^ w2 ^ w3 ^ {15'd0, flip};
    put_word(w0);
    put_word(w1);
    put_word(w2);
    put_word(w3);
    if (rdy_last) bus.cmd_ready_in = 1'b1;
    put_word(w4);
  endtask

  initial begin
    bus.pipe_write_in = 1'b0;
    bus.data_in       = 16'h0000;
    bus.cmd_ready_in  = 1'b0;
    rst_n             = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 44'(bus.cmd_valid_out), 44'd0);
    check("rst_payload", cur_cmd(), 44'd0);
    check("rst_frame_cnt", 44'(bus.frame_count_out), 44'd0);
    check("rst_err_cnt", 44'(bus.err_count_out), 44'd0);
    check("rst_overflow", 44'(bus.overflow_out), 44'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_ready_in = 1'b1;

    // Reference frame with hand-computed checksum C550.
    exp_q.push_back(pk(4'd0, 8'h12, 32'hDEADBEEF));
    put_word(16'hA500);
    put_word(16'h0012);
    put_word(16'hDEAD);
    put_word(16'hBEEF);
    put_word(16'hC550);
    check("A_valid_next_cycle", 44'(bus.cmd_valid_out), 44'd1);
    check("A_payload_out", cur_cmd(), pk(4'd0, 8'h12, 32'hDEADBEEF));
    check("A_frame_cnt", 44'(bus.frame_count_out), 44'd1);
    idle(1);
    check("A_valid_falls", 44'(bus.cmd_valid_out), 44'd0);

    // Same frame with checksum bit 0 flipped.
    put_word(16'hA500);
    put_word(16'h0012);
    put_word(16'hDEAD);
    put_word(16'hBEEF);
    put_word(16'hC551);
    check("badcs_no_valid", 44'(bus.cmd_valid_out), 44'd0);
    check("badcs_err_cnt", 44'(bus.err_count_out), 44'd1);
    check("badcs_frame_cnt", 44'(bus.frame_count_out), 44'd1);
    exp_q.push_back(pk(4'd3, 8'h40, 32'h12345678));
    send_frame(8'd3, 8'h40, 32'h12345678, 8'h00, 1'b0, 1'b0);
    idle(1);
    check("B_frame_cnt", 44'(bus.frame_count_out), 44'd2);

    // Stray word in HUNT, then a frame on the highest legal channel.
    put_word(16'h1234);
    check("stray_err_cnt", 44'(bus.err_count_out), 44'd2);
    exp_q.push_back(pk(4'd5, 8'h7F, 32'hCAFEF00D));
    send_frame(8'd5, 8'h7F, 32'hCAFEF00D, 8'h00, 1'b0, 1'b0);
    idle(1);
    check("C_frame_cnt", 44'(bus.frame_count_out), 44'd3);
    check("C_err_cnt", 44'(bus.err_count_out), 44'd2);

    // Held command consumed on the same cycle the next frame completes.
    bus.cmd_ready_in = 1'b0;
    exp_q.push_back(pk(4'd1, 8'h01, 32'h11111111));
    send_frame(8'd1, 8'h01, 32'h11111111, 8'h00, 1'b0, 1'b0);
    idle(3);
    check("X_held", 44'(bus.cmd_valid_out), 44'd1);
    exp_q.push_back(pk(4'd2, 8'h02, 32'h22222222));
    send_frame(8'd2, 8'h02, 32'h22222222, 8'h00, 1'b0, 1'b1);
    check("Y_valid_stays", 44'(bus.cmd_valid_out), 44'd1);
    check("Y_payload_out", cur_cmd(), pk(4'd2, 8'h02, 32'h22222222));
    check("Y_no_overflow", 44'(bus.overflow_out), 44'd0);
    check("Y_frame_cnt", 44'(bus.frame_count_out), 44'd5);
    idle(2);
    check("Y_drained", 44'(bus.cmd_valid_out), 44'd0);

    // Second frame arrives while first is held and not consumed.
    bus.cmd_ready_in = 1'b0;
    exp_q.push_back(pk(4'd4, 8'h44, 32'h44444444));
    send_frame(8'd4, 8'h44, 32'h44444444, 8'h00, 1'b0, 1'b0);
    send_frame(8'd0, 8'h55, 32'h55555555, 8'h00, 1'b0, 1'b0);
    check("drop_overflow", 44'(bus.overflow_out), 44'd1);
    check("drop_held_payload", cur_cmd(), pk(4'd4, 8'h44, 32'h44444444));
    check("drop_frame_cnt", 44'(bus.frame_count_out), 44'd6);
    check("drop_err_cnt", 44'(bus.err_count_out), 44'd2);
    bus.cmd_ready_in = 1'b1;
    idle(2);
    check("drop_drained", 44'(bus.cmd_valid_out), 44'd0);
    check("overflow_sticky", 44'(bus.overflow_out), 44'd1);

    // Idle timeout after two words: one cycle short, then exactly at the limit.
    put_word(16'hA500);
    put_word(16'h0012);
    idle(1023);
    check("timeout_not_yet", 44'(bus.err_count_out), 44'd2);
    idle(1);
    check("timeout_err_cnt", 44'(bus.err_count_out), 44'd3);
    send_frame(8'd6, 8'h10, 32'h66666666, 8'h00, 1'b0, 1'b0);
    idle(1);
    check("chan6_err_cnt", 44'(bus.err_count_out), 44'd4);
    check("chan6_no_valid", 44'(bus.cmd_valid_out), 44'd0);
    send_frame(8'd0, 8'h10, 32'h77777777, 8'h01, 1'b0, 1'b0);
    idle(1);
    check("w1hi_err_cnt", 44'(bus.err_count_out), 44'd5);
    exp_q.push_back(pk(4'd0, 8'h33, 32'h0BADF00D));
    send_frame(8'd0, 8'h33, 32'h0BADF00D, 8'h00, 1'b0, 1'b0);
    idle(1);
    check("post_timeout_frame_cnt", 44'(bus.frame_count_out), 44'd7);

    // Asynchronous reset mid-frame with a command held and overflow set.
    bus.cmd_ready_in = 1'b0;
    send_frame(8'd1, 8'hAA, 32'hAAAAAAAA, 8'h00, 1'b0, 1'b0);
    put_word(16'hA502);
    put_word(16'h0021);
    put_word(16'h1357);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 44'(bus.cmd_valid_out), 44'd0);
    check("arst_payload", cur_cmd(), 44'd0);
    check("arst_frame_cnt", 44'(bus.frame_count_out), 44'd0);
    check("arst_err_cnt", 44'(bus.err_count_out), 44'd0);
    check("arst_overflow", 44'(bus.overflow_out), 44'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_ready_in = 1'b1;
    exp_q.push_back(pk(4'd2, 8'h21, 32'h13572468));
    send_frame(8'd2, 8'h21, 32'h13572468, 8'h00, 1'b0, 1'b0);
    idle(1);
    check("fresh_frame_cnt", 44'(bus.frame_count_out), 44'd1);
    check("fresh_err_cnt", 44'(bus.err_count_out), 44'd0);
    idle(2);
    check("queue_empty", 44'(exp_q.size()), 44'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
